alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Round-robin arbiter that shares one `alu_multi_cycle` instance between `NUM_REQ` requesters. It sits between the requester-side operand/result buses and the single ALU port. It grants the ALU for one whole transaction, from the first operand beat through `result_last`, and steers the result beats back to the granted requester only. It also flags result beats that arrive while no transaction is awaiting a result.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `OP_WIDTH`, 3: opcode width.
- `OPERAND_BUS_WIDTH`, 8: width of each of `a` and `b` per beat.
- `RESULT_BUS_WIDTH`, 16: result beat width.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset. **Asynchronous, active-low.**
- `req_operand_valid`  in  NUM_REQ  operand beat valid, one bit per requester.
- `req_op`  in  NUM_REQ*OP_WIDTH  opcode. Requester i occupies slice [i*OP_WIDTH +: OP_WIDTH].
- `req_a`, `req_b`  in  NUM_REQ*OPERAND_BUS_WIDTH  operand beats, sliced the same way.
- `req_operand_last`  in  NUM_REQ  marks the final operand beat of a transaction.
- `req_ready`  out  NUM_REQ  per-requester beat accept.
- `req_result_valid`  out  NUM_REQ  result beat valid, asserted to the owner only.
- `req_result`  out  RESULT_BUS_WIDTH  result data, broadcast to all requesters.
- `req_result_last`, `req_result_rst`  out  1  broadcast copies of the ALU flags.
- `alu_operand_valid`, `alu_operand_last`  out  1  to ALU.
- `alu_op`  out  OP_WIDTH  to ALU.
- `alu_a`, `alu_b`  out  OPERAND_BUS_WIDTH  to ALU.
- `alu_ready`  in  1  ALU accepts operand beat.
- `alu_result_valid`, `alu_result_last`, `alu_result_rst`  in  1  from ALU.
- `alu_result`  in  RESULT_BUS_WIDTH  from ALU.
- `grant`  out  NUM_REQ  one-hot owner; all zeros when idle.
- `busy`  out  1  asserted in S_OPER or S_RES.
- `err_unexpected_result`  out  1  sticky error flag, cleared only by reset.

## Operation
- State machine has three states:
  - S_IDLE: no owner.
  - S_OPER: forwarding the owner's operand beats.
  - S_RES: awaiting the owner's result beats.
- S_IDLE to S_OPER:
  - Triggered when any `req_operand_valid` bit is 1.
  - Owner is the first requesting index at or after `rr_ptr`, wrapping modulo NUM_REQ.
  - `grant` is registered one-hot.
- In S_OPER:
  - ALU port takes the owner's valid, op, a, b and last, combinationally muxed.
  - `req_ready[owner]` = `alu_ready`; all other `req_ready` bits are 0.
  - An accepted beat is `alu_operand_valid` && `alu_ready`.
  - An accepted beat with last = 1 moves the FSM to S_RES.
  - Ownership is locked: if the owner deasserts valid mid-transaction, the grant is held and no other requester is served.
- In S_RES:
  - `req_result_valid[owner]` = `alu_result_valid`; all other bits are 0.
  - Data and flags pass through combinationally.
  - A beat with `alu_result_valid` && `alu_result_last` moves the FSM to S_IDLE.
  - On that same beat, `rr_ptr` <= (owner+1) mod NUM_REQ.
- Outside S_RES:
  - All ALU outputs that are gated by state are driven 0.
  - `alu_result_valid` = 1 is dropped: no requester sees it, and `err_unexpected_result` is set.
- Requests from non-owners are ignored (ready = 0) and are not queued. Requesters hold valid until they are served.

## Timing
- Reset values:
  - `grant`, `busy`, `err_unexpected_result`: 0.
  - `req_ready`, `req_result_valid`: 0.
  - `alu_operand_valid`, `alu_operand_last`, `alu_op`, `alu_a`, `alu_b`: 0.
  - `rr_ptr` = 0; state = S_IDLE.
- Arbitration latency is 1 cycle: a request sampled in S_IDLE at edge k gives `grant`/`req_ready` from cycle k+1.
- Operand and result paths add zero cycles of latency.
- Turnaround: the edge that accepts `result_last` returns the FSM to S_IDLE. The next grant is issued on the following edge, so there are 2 edges between transactions.
- A single-beat transaction is valid: an accepted beat with last = 1 in its first S_OPER cycle goes to S_RES on the next edge.
- `alu_result_last` without `alu_result_valid` is ignored.
- Reset asserted mid-transaction:
  - All outputs go to reset values immediately, asynchronously.
  - The in-flight transaction is abandoned.
  - After release, the first grant follows the normal 1-cycle latency.
- The pointer wraps: owner NUM_REQ-1 sets `rr_ptr` = 0.

## Test plan
- Single requester: NUM_REQ=4; req 2 sends op=3, 2 beats, the last with last = 1. Required: `grant`=4'b0100 one cycle after valid, both beats reach the ALU, the result reaches `req_result_valid[2]` only, then `busy`=0.
- Fairness: reqs 0, 1 and 3 request continuously. Required grant order 0, 1, 3, 0, 1, 3, with no requester granted twice in a row.
- Wrap-around: after owner 3 completes, reqs 0 and 3 both request. Required: `grant`=4'b0001.
- Lock under backpressure: owner 1 holds `alu_ready`=0 for 5 cycles while req 0 requests. Required: `grant` stays 4'b0010 and `req_ready[0]`=0 throughout.
- Unexpected result: `alu_result_valid`=1 pulsed in S_IDLE. Required: `req_result_valid`=0 and `err_unexpected_result`=1, still 1 after 100 cycles.
- Reset mid-operation: `rst`=0 asserted while in S_RES. Required: all outputs 0 in the same cycle; after release, req 2 is granted as `grant`=4'b0100 one cycle after its valid.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one multi-cycle ALU between NUM_REQ requesters. A round-robin pick
// in idle selects an owner, which then holds the ALU for a whole transaction:
// every operand beat up to operand_last, then every result beat up to
// result_last. Result beats are steered to the owner only. A result beat
// that arrives while no transaction is waiting for one is dropped and raises
// a sticky error flag.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   req_operand_valid/_last  per-requester operand beat handshake
//   req_op, req_a, req_b     per-requester operand fields, slice i = req i
//   req_ready                per-requester beat accept (owner only)
//   req_result_valid         per-requester result valid (owner only)
//   req_result(_last/_rst)   result data and flags, broadcast
//   alu_operand_*, alu_op,
//   alu_a, alu_b, alu_ready  operand port toward the ALU
//   alu_result_*             result port from the ALU
//   grant                    one-hot owner, zero when idle
//   busy                     transaction in progress
//   err_unexpected_result    sticky, cleared only by reset
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int NUM_REQ           = 4,
  parameter int OP_WIDTH          = 3,
  parameter int OPERAND_BUS_WIDTH = 8,
  parameter int RESULT_BUS_WIDTH  = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     req_operand_valid,
  input  logic [NUM_REQ*OP_WIDTH-1:0]            req_op,
  input  logic [NUM_REQ*OPERAND_BUS_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*OPERAND_BUS_WIDTH-1:0]   req_b,
  input  logic [NUM_REQ-1:0]                     req_operand_last,
  output logic [NUM_REQ-1:0]                     req_ready,
  output logic [NUM_REQ-1:0]                     req_result_valid,
  output logic [RESULT_BUS_WIDTH-1:0]            req_result,
  output logic                                   req_result_last,
  output logic                                   req_result_rst,
  output logic                                   alu_operand_valid,
  output logic                                   alu_operand_last,
  output logic [OP_WIDTH-1:0]                    alu_op,
  output logic [OPERAND_BUS_WIDTH-1:0]           alu_a,
  output logic [OPERAND_BUS_WIDTH-1:0]           alu_b,
  input  logic                                   alu_ready,
  input  logic                                   alu_result_valid,
  input  logic                                   alu_result_last,
  input  logic                                   alu_result_rst,
  input  logic [RESULT_BUS_WIDTH-1:0]            alu_result,
  output logic [NUM_REQ-1:0]                     grant,
  output logic                                   busy,
  output logic                                   err_unexpected_result
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OPER = 2'd1,
    S_RES  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 err_q, err_d;

  logic [IDX_W-1:0]     pick_idx_s;
  logic [IDX_W-1:0]     ptr_next_s;
  logic                 beat_accept_s;
  logic                 result_done_s;

  // First requesting index at or after ptr, wrapping modulo NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [NUM_REQ-1:0] valid_vec,
    input logic [IDX_W-1:0]   ptr
  );
    logic [IDX_W-1:0] sel;
    logic             found;
    int               idx;
    sel   = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && valid_vec[idx]) begin
        sel   = IDX_W'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return sel;
  endfunction

  assign pick_idx_s    = rr_pick(req_operand_valid, rr_ptr_q);
  assign ptr_next_s    = (owner_q == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}}
                                                          : owner_q + {{(IDX_W-1){1'b0}}, 1'b1};
  assign beat_accept_s = alu_operand_valid && alu_ready;
  assign result_done_s = (state_q == S_RES) && alu_result_valid && alu_result_last;

  // Next-state, owner selection, pointer advance and error capture.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    // A result beat is only legitimate while the owner awaits results.
    err_d    = err_q | (alu_result_valid && (state_q != S_RES));
    case (state_q)
      S_IDLE: begin
        if (|req_operand_valid) begin
          state_d = S_OPER;
          owner_d = pick_idx_s;
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
        end else begin
          grant_d = {NUM_REQ{1'b0}};
        end
      end
      S_OPER: begin
        // Ownership stays locked even if the owner drops valid.
        if (beat_accept_s && alu_operand_last) begin
          state_d = S_RES;
        end else begin
          state_d = S_OPER;
        end
      end
      S_RES: begin
        // result_last without result_valid is not a beat.
        if (result_done_s) begin
          state_d  = S_IDLE;
          grant_d  = {NUM_REQ{1'b0}};
          rr_ptr_d = ptr_next_s;
        end else begin
          state_d = S_RES;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = {NUM_REQ{1'b0}};
        owner_d = {IDX_W{1'b0}};
      end
    endcase
  end

  // State, owner, pointer and sticky error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      grant_q  <= {NUM_REQ{1'b0}};
      owner_q  <= {IDX_W{1'b0}};
      rr_ptr_q <= {IDX_W{1'b0}};
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  // Zero-latency operand/result steering, gated by state so that every
  // steered output collapses to zero as soon as the state register resets.
  always_comb begin
    req_ready         = {NUM_REQ{1'b0}};
    req_result_valid  = {NUM_REQ{1'b0}};
    req_result        = {RESULT_BUS_WIDTH{1'b0}};
    req_result_last   = 1'b0;
    req_result_rst    = 1'b0;
    alu_operand_valid = 1'b0;
    alu_operand_last  = 1'b0;
    alu_op            = {OP_WIDTH{1'b0}};
    alu_a             = {OPERAND_BUS_WIDTH{1'b0}};
    alu_b             = {OPERAND_BUS_WIDTH{1'b0}};
    case (state_q)
      S_OPER: begin
        alu_operand_valid = req_operand_valid[owner_q];
        alu_operand_last  = req_operand_last[owner_q];
        alu_op            = req_op[owner_q*OP_WIDTH +: OP_WIDTH];
        alu_a             = req_a[owner_q*OPERAND_BUS_WIDTH +: OPERAND_BUS_WIDTH];
        alu_b             = req_b[owner_q*OPERAND_BUS_WIDTH +: OPERAND_BUS_WIDTH];
        req_ready         = grant_q & {NUM_REQ{alu_ready}};
      end
      S_RES: begin
        req_result_valid  = grant_q & {NUM_REQ{alu_result_valid}};
        req_result        = alu_result;
        req_result_last   = alu_result_last;
        req_result_rst    = alu_result_rst;
      end
      default: begin
        req_ready         = {NUM_REQ{1'b0}};
        req_result_valid  = {NUM_REQ{1'b0}};
      end
    endcase
  end

  assign grant                 = grant_q;
  assign busy                  = (state_q != S_IDLE);
  assign err_unexpected_result = err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_operand_valid;
  logic [11:0] req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_operand_last;
  logic [3:0]  req_ready;
  logic [3:0]  req_result_valid;
  logic [15:0] req_result;
  logic        req_result_last;
  logic        req_result_rst;
  logic        alu_operand_valid;
  logic        alu_operand_last;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_ready;
  logic        alu_result_valid;
  logic        alu_result_last;
  logic        alu_result_rst;
  logic [15:0] alu_result;
  logic [3:0]  grant;
  logic        busy;
  logic        err_unexpected_result;

  int n_cmp;
  int n_bad;

  alu_share_arbiter #(
    .NUM_REQ(4), .OP_WIDTH(3), .OPERAND_BUS_WIDTH(8), .RESULT_BUS_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_operand_valid(req_operand_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_operand_last(req_operand_last),
    .req_ready(req_ready), .req_result_valid(req_result_valid),
    .req_result(req_result), .req_result_last(req_result_last),
    .req_result_rst(req_result_rst),
    .alu_operand_valid(alu_operand_valid), .alu_operand_last(alu_operand_last),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_ready(alu_ready),
    .alu_result_valid(alu_result_valid), .alu_result_last(alu_result_last),
    .alu_result_rst(alu_result_rst), .alu_result(alu_result),
    .grant(grant), .busy(busy), .err_unexpected_result(err_unexpected_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic set_req(input int idx, input logic v, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b, input logic last);
    req_operand_valid[idx]  = v;
    req_op[idx*3 +: 3]      = op;
    req_a[idx*8 +: 8]       = a;
    req_b[idx*8 +: 8]       = b;
    req_operand_last[idx]   = last;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_operand_valid = 4'b0000; req_op = 12'h000; req_a = 32'h0; req_b = 32'h0;
    req_operand_last = 4'b0000; alu_ready = 1'b0; alu_result_valid = 1'b0;
    alu_result_last = 1'b0; alu_result_rst = 1'b0; alu_result = 16'h0000;
    #1;
    n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL reset_grant got=%b exp=%b", grant, 4'b0000); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (err_unexpected_result !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err_unexpected_result); end
    n_cmp++; if ({req_ready, req_result_valid} !== 8'h00) begin n_bad++; $display("FAIL reset_ready_rv got=%h exp=00", {req_ready, req_result_valid}); end
    n_cmp++; if ({alu_operand_valid, alu_operand_last, alu_op, alu_a, alu_b} !== 21'h0) begin n_bad++; $display("FAIL reset_alu_port got=%h exp=0", {alu_operand_valid, alu_operand_last, alu_op, alu_a, alu_b}); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fairness();
    int exp_owner [6] = '{0, 1, 3, 0, 1, 3};
    logic [3:0] prev_grant;
    logic [3:0] exp_g;
    prev_grant = 4'b0000;
    alu_ready = 1'b1;
    set_req(0, 1'b1, 3'd1, 8'h10, 8'h20, 1'b1);
    set_req(1, 1'b1, 3'd2, 8'h11, 8'h21, 1'b1);
    set_req(3, 1'b1, 3'd4, 8'h13, 8'h23, 1'b1);
    for (int t = 0; t < 6; t++) begin
      exp_g = 4'b0001 << exp_owner[t];
      @(posedge clk); @(negedge clk);
      n_cmp++; if (grant !== exp_g) begin n_bad++; $display("FAIL fair_grant[%0d] got=%b exp=%b", t, grant, exp_g); end
      n_cmp++; if (alu_a !== (8'h10 + 8'(exp_owner[t]))) begin n_bad++; $display("FAIL fair_alu_a[%0d] got=%h exp=%h", t, alu_a, 8'h10 + 8'(exp_owner[t])); end
      n_cmp++; if (grant === prev_grant) begin n_bad++; $display("FAIL fair_repeat[%0d] got=%b prev=%b", t, grant, prev_grant); end
      prev_grant = grant;
      @(posedge clk); @(negedge clk);
      alu_result_valid = 1'b1; alu_result_last = 1'b1; alu_result = 16'h0100 + 16'(t);
      #1;
      n_cmp++; if (req_result_valid !== exp_g) begin n_bad++; $display("FAIL fair_result_valid[%0d] got=%b exp=%b", t, req_result_valid, exp_g); end
      @(posedge clk); @(negedge clk);
      alu_result_valid = 1'b0; alu_result_last = 1'b0;
      if (t == 5) req_operand_valid = 4'b0000;
    end
  endtask

  task automatic test_wrap();
    set_req(0, 1'b1, 3'd1, 8'hA0, 8'hB0, 1'b1);
    set_req(3, 1'b1, 3'd1, 8'hA3, 8'hB3, 1'b1);
    @(posedge clk); @(negedge clk);
    n_cmp++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL wrap_grant got=%b exp=%b", grant, 4'b0001); end
    @(posedge clk); @(negedge clk);
    req_operand_valid = 4'b0000;
    alu_result_valid = 1'b1; alu_result_last = 1'b1;
    @(posedge clk); @(negedge clk);
    alu_result_valid = 1'b0; alu_result_last = 1'b0;
  endtask

  task automatic test_single();
    alu_ready = 1'b1;
    set_req(2, 1'b1, 3'd3, 8'h11, 8'h22, 1'b0);
    #1;
    n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL single_grant_early got=%b exp=%b", grant, 4'b0000); end
    @(posedge clk); @(negedge clk);
    n_cmp++; if (grant !== 4'b0100) begin n_bad++; $display("FAIL single_grant got=%b exp=%b", grant, 4'b0100); end
    n_cmp++; if ({alu_operand_valid, alu_operand_last, alu_op, alu_a, alu_b} !== {1'b1, 1'b0, 3'd3, 8'h11, 8'h22}) begin n_bad++; $display("FAIL single_beat0 got=%h exp=%h", {alu_operand_valid, alu_operand_last, alu_op, alu_a, alu_b}, {1'b1, 1'b0, 3'd3, 8'h11, 8'h22}); end
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL single_ready got=%b exp=%b", req_ready, 4'b0100); end
    @(posedge clk); @(negedge clk);
    set_req(2, 1'b1, 3'd3, 8'h33, 8'h44, 1'b1);
    #1;
    n_cmp++; if ({alu_operand_valid, alu_operand_last, alu_a, alu_b} !== {1'b1, 1'b1, 8'h33, 8'h44}) begin n_bad++; $display("FAIL single_beat1 got=%h exp=%h", {alu_operand_valid, alu_operand_last, alu_a, alu_b}, {1'b1, 1'b1, 8'h33, 8'h44}); end
    @(posedge clk); @(negedge clk);
    req_operand_valid = 4'b0000;
    alu_result_last = 1'b1; alu_result_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_last_no_valid busy got=%b exp=1", busy); end
    alu_result_valid = 1'b1; alu_result = 16'hBEEF;
    #1;
    n_cmp++; if (req_result_valid !== 4'b0100) begin n_bad++; $display("FAIL single_result_valid got=%b exp=%b", req_result_valid, 4'b0100); end
    n_cmp++; if ({req_result, req_result_last} !== {16'hBEEF, 1'b1}) begin n_bad++; $display("FAIL single_result_data got=%h exp=%h", {req_result, req_result_last}, {16'hBEEF, 1'b1}); end
    @(posedge clk); @(negedge clk);
    alu_result_valid = 1'b0; alu_result_last = 1'b0;
    n_cmp++; if ({busy, grant} !== 5'b0_0000) begin n_bad++; $display("FAIL single_idle got=%b exp=%b", {busy, grant}, 5'b0_0000); end
  endtask

  task automatic test_lock();
    alu_ready = 1'b0;
    set_req(1, 1'b1, 3'd6, 8'h55, 8'h66, 1'b0);
    @(posedge clk); @(negedge clk);
    n_cmp++; if (grant !== 4'b0010) begin n_bad++; $display("FAIL lock_grant got=%b exp=%b", grant, 4'b0010); end
    set_req(0, 1'b1, 3'd1, 8'h01, 8'h02, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); @(negedge clk);
      n_cmp++; if ({grant, req_ready} !== 8'b0010_0000) begin n_bad++; $display("FAIL lock_hold[%0d] got=%b exp=%b", c, {grant, req_ready}, 8'b0010_0000); end
    end
    req_operand_valid[1] = 1'b0; alu_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    n_cmp++; if ({grant, req_ready, alu_operand_valid} !== 9'b0010_0010_0) begin n_bad++; $display("FAIL lock_owner_idle got=%b exp=%b", {grant, req_ready, alu_operand_valid}, 9'b0010_0010_0); end
    set_req(1, 1'b1, 3'd6, 8'h77, 8'h88, 1'b1);
    @(posedge clk); @(negedge clk);
    req_operand_valid = 4'b0000;
    alu_result_valid = 1'b1; alu_result_last = 1'b1;
    @(posedge clk); @(negedge clk);
    alu_result_valid = 1'b0; alu_result_last = 1'b0;
  endtask

  task automatic test_unexpected();
    n_cmp++; if (err_unexpected_result !== 1'b0) begin n_bad++; $display("FAIL unexp_err_before got=%b exp=0", err_unexpected_result); end
    alu_result_valid = 1'b1; alu_result_last = 1'b1; alu_result = 16'hDEAD;
    #1;
    n_cmp++; if ({busy, req_result_valid} !== 5'b0_0000) begin n_bad++; $display("FAIL unexp_dropped got=%b exp=%b", {busy, req_result_valid}, 5'b0_0000); end
    @(posedge clk); @(negedge clk);
    alu_result_valid = 1'b0; alu_result_last = 1'b0;
    n_cmp++; if (err_unexpected_result !== 1'b1) begin n_bad++; $display("FAIL unexp_err_set got=%b exp=1", err_unexpected_result); end
    repeat (100) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (err_unexpected_result !== 1'b1) begin n_bad++; $display("FAIL unexp_err_sticky got=%b exp=1", err_unexpected_result); end
  endtask

  task automatic test_reset_mid();
    alu_ready = 1'b1;
    set_req(2, 1'b1, 3'd5, 8'h5A, 8'hA5, 1'b1);
    @(posedge clk); @(posedge clk); @(negedge clk);
    req_operand_valid = 4'b0000;
    alu_result_valid = 1'b1; alu_result_last = 1'b0; alu_result = 16'h1234;
    #1;
    n_cmp++; if ({busy, req_result_valid} !== 5'b1_0100) begin n_bad++; $display("FAIL rstmid_in_res got=%b exp=%b", {busy, req_result_valid}, 5'b1_0100); end
    set_req(2, 1'b1, 3'd5, 8'h5A, 8'hA5, 1'b1);
    rst = 1'b0;
    #1;
    n_cmp++; if ({grant, busy, err_unexpected_result, req_ready, req_result_valid} !== 14'h0) begin n_bad++; $display("FAIL rstmid_ctrl got=%h exp=0", {grant, busy, err_unexpected_result, req_ready, req_result_valid}); end
    n_cmp++; if ({alu_operand_valid, alu_operand_last, alu_op, alu_a, alu_b, req_result} !== 37'h0) begin n_bad++; $display("FAIL rstmid_data got=%h exp=0", {alu_operand_valid, alu_operand_last, alu_op, alu_a, alu_b, req_result}); end
    alu_result_valid = 1'b0;
    req_operand_valid = 4'b0000;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    set_req(2, 1'b1, 3'd5, 8'h5A, 8'hA5, 1'b1);
    #1;
    n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL rstmid_grant_early got=%b exp=%b", grant, 4'b0000); end
    @(posedge clk); @(negedge clk);
    n_cmp++; if ({grant, req_ready} !== 8'b0100_0100) begin n_bad++; $display("FAIL rstmid_regrant got=%b exp=%b", {grant, req_ready}, 8'b0100_0100); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_fairness();
    test_wrap();
    test_single();
    test_lock();
    test_unexpected();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
